// File: rtl/sha_cmd_ctrl.sv
// sha_cmd_ctrl: UART byte-command front end that loads, starts and reports results from a bank of SHA units.
module sha_cmd_ctrl #(
  parameter int          NUM_UNITS      = 4,
  parameter logic [31:0] NONCE_STRIDE   = 32'h0020_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      sha_rst,
  output logic                      sha_start,
  output logic                      busy,
  output logic [95:0]               sha_data,
  output logic [255:0]              sha_state,
  output logic [255:0]              sha_target,
  output logic [31:0]               sha_position,
  output logic [NUM_UNITS*32-1:0]   sha_nonce_base,
  input  logic [NUM_UNITS-1:0]      sha_found,
  input  logic [NUM_UNITS*32-1:0]   sha_nonce
);
  typedef enum logic [2:0] {IDLE, READY, LOAD, HASH, SEND} state_t;
  state_t                    state_q, state_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      tx_valid_q, tx_valid_d;
  logic                      sha_rst_q, sha_rst_d;
  logic                      sha_start_q, sha_start_d;
  logic [95:0]               data_q, data_d;
  logic [255:0]              hstate_q, hstate_d;
  logic [255:0]              target_q, target_d;
  logic [31:0]               pos_q, pos_d;
  logic [31:0]               base_q, base_d;
  logic [NUM_UNITS*32-1:0]   nbase_q, nbase_d;
  logic [6:0]                cnt_q, cnt_d;
  logic [7:0]                csum_q, csum_d;
  logic [31:0]               gap_q, gap_d;
  logic [3:0]                idx_q, idx_d;
  logic [31:0]               res_q, res_d;
  logic [2:0]                send_q, send_d;
  logic [3:0]                found_idx;
  logic [31:0]               found_nonce;
  logic                      rx_fire;
  assign rx_ready       = !tx_valid_q && state_q != SEND;
  assign rx_fire        = rx_valid && rx_ready;
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign sha_rst        = sha_rst_q;
  assign sha_start      = sha_start_q;
  assign busy           = state_q == HASH;
  assign sha_data       = data_q;
  assign sha_state      = hstate_q;
  assign sha_target     = target_q;
  assign sha_position   = pos_q;
  assign sha_nonce_base = nbase_q;
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q && !tx_ready;
    sha_rst_d   = sha_rst_q;
    sha_start_d = 1'b0;
    data_d      = data_q;
    hstate_d    = hstate_q;
    target_d    = target_q;
    pos_d       = pos_q;
    base_d      = base_q;
    nbase_d     = nbase_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    res_d       = res_q;
    send_d      = send_q;
    found_idx   = '0;
    found_nonce = '0;
    // Scan downward so the lowest asserting unit wins.
    for (int i = NUM_UNITS - 1; i >= 0; i--)
      if (sha_found[i]) begin
        found_idx   = 4'(i);
        found_nonce = sha_nonce[32*i +: 32];
      end
    case (state_q)
      LOAD: begin
        if (rx_fire) begin
          gap_d = '0;
          if (cnt_q != 7'd84) begin
            cnt_d  = cnt_q + 7'd1;
            csum_d = csum_q ^ rx_data;
            if (cnt_q < 7'd12)      data_d   = {rx_data, data_q[95:8]};
            else if (cnt_q < 7'd44) hstate_d = {hstate_q[247:0], rx_data};
            else if (cnt_q < 7'd76) target_d = {rx_data, target_q[255:8]};
            else if (cnt_q < 7'd80) base_d   = {rx_data, base_q[31:8]};
            else                    pos_d    = {rx_data, pos_q[31:8]};
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = csum_q == rx_data ? "S" : "C";
            state_d    = csum_q == rx_data ? HASH : READY;
            sha_start_d = csum_q == rx_data;
            if (csum_q == rx_data)
              for (int i = 0; i < NUM_UNITS; i++)
                nbase_d[32*i +: 32] = base_q + 32'(i) * NONCE_STRIDE;
          end
        end else if (gap_q == TIMEOUT_CYCLES) begin
          tx_valid_d = 1'b1;
          tx_data_d  = "T";
          state_d    = READY;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      SEND: begin
        if (!tx_valid_q) begin
          if (send_q == 3'd6) begin
            sha_rst_d = 1'b1;
            state_d   = IDLE;
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = send_q == 3'd0 ? "Y" : send_q == 3'd1 ? {4'h0, idx_q} : res_q[7:0];
            res_d      = send_q >= 3'd2 ? res_q >> 8 : res_q;
            send_d     = send_q + 3'd1;
          end
        end
      end
      default: begin
        if (rx_fire) begin
          tx_valid_d = 1'b1;
          if (rx_data == "R") begin
            tx_data_d = "O";
            sha_rst_d = 1'b1;
            state_d   = IDLE;
          end else if (rx_data == "H" && state_q != HASH) begin
            tx_data_d = "1";
            sha_rst_d = 1'b0;
            state_d   = READY;
          end else if (rx_data == "L" && state_q == READY) begin
            tx_valid_d = 1'b0;
            cnt_d      = '0;
            csum_d     = '0;
            gap_d      = '0;
            state_d    = LOAD;
          end else begin
            tx_data_d = rx_data == "Q" ? (state_q == HASH ? "B" : "I") : "E";
          end
        end
        if (state_q == HASH && |sha_found && !(rx_fire && rx_data == "R")) begin
          state_d = SEND;
          idx_d   = found_idx;
          res_d   = found_nonce;
          send_d  = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      sha_rst_q   <= 1'b1;
      sha_start_q <= 1'b0;
      data_q      <= '0;
      hstate_q    <= '0;
      target_q    <= '0;
      pos_q       <= '0;
      base_q      <= '0;
      nbase_q     <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      res_q       <= '0;
      send_q      <= '0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      sha_rst_q   <= sha_rst_d;
      sha_start_q <= sha_start_d;
      data_q      <= data_d;
      hstate_q    <= hstate_d;
      target_q    <= target_d;
      pos_q       <= pos_d;
      base_q      <= base_d;
      nbase_q     <= nbase_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      send_q      <= send_d;
    end
  end
endmodule

// File: tb/tb_sha_cmd_ctrl.sv
// tb_sha_cmd_ctrl: directed command/load/hash/send scenarios for sha_cmd_ctrl with hand-computed responses.
module tb_sha_cmd_ctrl;
  localparam int N  = 4;
  localparam int TO = 50;
  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [7:0]     rx_data = '0;
  logic           rx_valid = 1'b0;
  logic           rx_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic           sha_rst, sha_start, busy;
  logic [95:0]    sha_data;
  logic [255:0]   sha_state, sha_target;
  logic [31:0]    sha_position;
  logic [N*32-1:0] sha_nonce_base;
  logic [N-1:0]   sha_found = '0;
  logic [N*32-1:0] sha_nonce = '0;
  int             n_checks = 0;
  int             n_errors = 0;
  int             start_cnt = 0;
  logic [7:0]     pay [84];
  logic [7:0]     cs;
  logic [95:0]    exp_data;
  logic [255:0]   exp_state, exp_target;
  sha_cmd_ctrl #(.NUM_UNITS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sha_rst(sha_rst), .sha_start(sha_start), .busy(busy),
    .sha_data(sha_data), .sha_state(sha_state), .sha_target(sha_target),
    .sha_position(sha_position), .sha_nonce_base(sha_nonce_base),
    .sha_found(sha_found), .sha_nonce(sha_nonce)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (sha_start) start_cnt++;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_ready_wait", 256'(rx_ready), 256'(1));
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic get_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!tx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) chk({tag, "_wait"}, 256'(tx_valid), 256'(1));
    else begin
      chk(tag, 256'(tx_data), 256'(exp));
      tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic load(input logic [7:0] xr);
    for (int p = 0; p < 84; p++) send_byte(pay[p]);
    send_byte(cs ^ xr);
  endtask
  initial begin
    int bad;
    int n;
    for (int p = 0; p < 84; p++) pay[p] = 8'(p * 7 + 3);
    pay[0] = "R";
    pay[1] = "H";
    pay[76] = 8'd10; pay[77] = 8'd0; pay[78] = 8'd0; pay[79] = 8'd0;
    pay[80] = 8'd5;  pay[81] = 8'd0; pay[82] = 8'd0; pay[83] = 8'd0;
    cs = '0;
    exp_data = '0;
    exp_state = '0;
    exp_target = '0;
    for (int p = 0; p < 84; p++) cs ^= pay[p];
    for (int p = 0; p < 12; p++) exp_data[7'(8*p) +: 8] = pay[p];
    for (int p = 12; p < 44; p++) exp_state[8'(255 - 8*(p-12)) -: 8] = pay[p];
    for (int p = 44; p < 76; p++) exp_target[8'(8*(p-44)) +: 8] = pay[p];
    repeat (3) @(negedge clk);
    chk("rst_sha_rst", 256'(sha_rst), 256'(1));
    chk("rst_tx_valid", 256'(tx_valid), 256'(0));
    chk("rst_tx_data", 256'(tx_data), 256'(0));
    chk("rst_rx_ready", 256'(rx_ready), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_nbase", 256'(sha_nonce_base), 256'(0));
    rstn = 1'b1;
    @(negedge clk);
    send_byte("H"); get_byte("H_idle", "1");
    chk("sha_rst_off", 256'(sha_rst), 256'(0));
    send_byte("Q"); get_byte("Q_ready", "I");
    send_byte("X"); get_byte("X_err", "E");
    send_byte("R"); get_byte("R_reset", "O");
    chk("sha_rst_on", 256'(sha_rst), 256'(1));
    send_byte("H"); get_byte("H_again", "1");
    send_byte("L");
    repeat (2) @(negedge clk);
    chk("L_silent", 256'(tx_valid), 256'(0));
    load(8'h00); get_byte("load_ok", "S");
    chk("start_once", 256'(start_cnt), 256'(1));
    chk("busy_hash", 256'(busy), 256'(1));
    chk("nonce_base", 256'(sha_nonce_base), 256'(128'h0060000A_0040000A_0020000A_0000000A));
    chk("position", 256'(sha_position), 256'(5));
    chk("data", 256'(sha_data), 256'(exp_data));
    chk("state", sha_state, exp_state);
    chk("target", sha_target, exp_target);
    send_byte("Q"); get_byte("Q_hash", "B");
    send_byte("H"); get_byte("H_hash", "E");
    sha_nonce[63:32]  = 32'hDEADBEEF;
    sha_nonce[127:96] = 32'h12345678;
    sha_found = 4'b1010;
    get_byte("send_Y", "Y");
    sha_found = '0;
    get_byte("send_idx", 8'h01);
    get_byte("send_n0", 8'hEF);
    get_byte("send_n1", 8'hBE);
    get_byte("send_n2", 8'hAD);
    get_byte("send_n3", 8'hDE);
    repeat (2) @(negedge clk);
    chk("post_send_rst", 256'(sha_rst), 256'(1));
    chk("post_send_busy", 256'(busy), 256'(0));
    send_byte("L"); get_byte("L_idle", "E");
    send_byte("H"); get_byte("H_bad", "1");
    send_byte("L");
    load(8'h01); get_byte("bad_csum", "C");
    chk("no_start_bad", 256'(start_cnt), 256'(1));
    send_byte("L");
    for (int p = 0; p < 40; p++) send_byte(pay[p]);
    repeat (TO - 5) @(negedge clk);
    chk("no_early_T", 256'(tx_valid), 256'(0));
    get_byte("timeout", "T");
    send_byte("L");
    load(8'h00); get_byte("reload_ok", "S");
    chk("start_twice", 256'(start_cnt), 256'(2));
    sha_found = 4'b0001;
    rx_data   = "R";
    rx_valid  = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    sha_found = '0;
    @(negedge clk);
    get_byte("R_wins", "O");
    repeat (3) @(negedge clk);
    chk("R_wins_no_tx", 256'(tx_valid), 256'(0));
    chk("R_wins_busy", 256'(busy), 256'(0));
    chk("R_wins_rst", 256'(sha_rst), 256'(1));
    send_byte("H"); get_byte("H_stall", "1");
    send_byte("L");
    load(8'h00); get_byte("stall_load", "S");
    sha_nonce[95:64] = 32'hA1B2C3D4;
    sha_found = 4'b0100;
    n = 0;
    while (!tx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!(tx_valid && tx_data == "Y" && !rx_ready)) bad++;
    end
    chk("stall_stable", 256'(bad), 256'(0));
    sha_found = '0;
    get_byte("stall_Y", "Y");
    get_byte("stall_idx", 8'h02);
    get_byte("stall_n0", 8'hD4);
    get_byte("stall_n1", 8'hC3);
    get_byte("stall_n2", 8'hB2);
    get_byte("stall_n3", 8'hA1);
    send_byte("H"); get_byte("H_abort", "1");
    send_byte("L");
    load(8'h00); get_byte("abort_load", "S");
    chk("abort_busy_pre", 256'(busy), 256'(1));
    rstn = 1'b0;
    #1;
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_sha_rst", 256'(sha_rst), 256'(1));
    chk("abort_nbase", 256'(sha_nonce_base), 256'(0));
    chk("abort_tx", 256'(tx_valid), 256'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sha_cmd_ctrl.md
SHA_CMD_CTRL -- requirements
Module: sha_cmd_ctrl

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of SHA units driven (legal range 1..16).
REQ-002 SHALL have parameter NONCE_STRIDE, default 32'h0020_0000, nonce offset between adjacent units.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, maximum inter-byte gap during LOAD.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports rx_data in 8, rx_valid in 1, rx_ready out 1: byte stream from UART receiver; a byte transfers when rx_valid & rx_ready at a clock edge.
REQ-007 SHALL have ports tx_data out 8, tx_valid out 1, tx_ready in 1: byte stream to UART transmitter; a byte transfers when tx_valid & tx_ready.
REQ-008 SHALL have ports sha_rst out 1 (unit reset), sha_start out 1 (one-cycle start pulse), busy out 1 (high in HASH).
REQ-009 SHALL have ports sha_data out 96, sha_state out 256, sha_target out 256, sha_position out 32, sha_nonce_base out NUM_UNITS*32.
REQ-010 SHALL have ports sha_found in NUM_UNITS and sha_nonce in NUM_UNITS*32 (unit i result at [32*i+:32]).

Function
REQ-011 SHALL implement states IDLE, READY, LOAD, HASH, SEND.
REQ-012 SHALL deassert rx_ready whenever tx_valid is high or state is SEND; otherwise rx_ready = 1.
REQ-013 SHALL hold tx_data/tx_valid stable until tx_ready; each response byte is queued on the cycle after the triggering rx transfer.
REQ-014 In IDLE/READY/HASH, byte 'R' SHALL assert sha_rst, respond 'O', go IDLE.
REQ-015 In IDLE/READY, 'H' SHALL deassert sha_rst, respond '1', go READY.
REQ-016 In READY, 'L' SHALL clear byte counter and checksum, respond nothing, go LOAD.
REQ-017 In any state but LOAD/SEND, 'Q' SHALL respond 'B' if HASH, else 'I'; state unchanged.
REQ-018 Any other byte outside LOAD (incl. 'L' in IDLE/HASH, 'H' in HASH) SHALL respond 'E', state unchanged.
REQ-019 In LOAD every byte is payload (binary-safe, no command decode); payload is 84 bytes then 1 checksum byte.
REQ-020 Payload byte p: p 0..11 -> sha_data[8p+:8]; p 12..43 -> sha_state[255-8(p-12)-:8] (first byte most significant); p 44..75 -> sha_target[8(p-44)+:8]; p 76..79 -> nonce base, little-endian; p 80..83 -> sha_position, little-endian.
REQ-021 Checksum SHALL be XOR of the 84 payload bytes; on match: sha_nonce_base[i] = base + i*NONCE_STRIDE (mod 2^32), one-cycle sha_start, respond 'S', go HASH.
REQ-022 On checksum mismatch SHALL respond 'C', no sha_start, go READY; previously captured outputs may be overwritten.
REQ-023 In LOAD, a gap of more than TIMEOUT_CYCLES cycles without rx transfer SHALL respond 'T' and go READY; gap counter saturates, resets on every byte.
REQ-024 In HASH, when |sha_found, SHALL latch lowest index i with sha_found[i] and sha_nonce of that unit in the same cycle, go SEND.
REQ-025 If 'R' transfers in the same cycle sha_found rises, 'R' SHALL win (respond 'O', result discarded).
REQ-026 SEND SHALL transmit 6 bytes: 'Y', index i, nonce bytes LSB first; then assert sha_rst for one cycle-then-hold as in IDLE and go IDLE.
REQ-027 sha_* configuration outputs SHALL change only in LOAD or at reset.

Reset
REQ-028 On rstn low: state IDLE, sha_rst=1, sha_start=0, busy=0, tx_valid=0, tx_data=0, rx_ready=1, all sha_* data outputs 0, counters 0.
REQ-029 Reset asserted mid-LOAD/HASH/SEND SHALL abort immediately with no further tx byte.

Verification
REQ-030 Reset, send 'H' -> '1'; 'Q' -> 'I'; 'X' -> 'E'; 'R' -> 'O', sha_rst=1.
REQ-031 'H','L', 84 bytes (base bytes 10 00 00 00, position 05 00 00 00), correct checksum -> 'S', sha_start one cycle, sha_nonce_base = {0x0060000A,0x0040000A,0x0020000A,0x0000000A}, sha_position=5.
REQ-032 Same load with checksum XORed with 0x01 -> 'C', no sha_start, next 'L' accepted.
REQ-033 In HASH, sha_found=4'b1010, sha_nonce[1]=0xDEADBEEF -> 'Y',0x01,0xEF,0xBE,0xAD,0xDE, then IDLE with sha_rst=1.
REQ-034 LOAD with 40 bytes then silence TIMEOUT_CYCLES+1 cycles -> 'T', state READY; payload bytes 'R'/'H' inside LOAD accepted as data.
REQ-035 tx_ready held low 100 cycles during SEND -> tx_data/tx_valid stable, rx_ready=0, no byte lost.
